// File: rtl/booth_wallace_mult_pipe.sv
// rtl/booth_wallace_mult_pipe.sv - 3-stage radix-4 Booth / Wallace-tree multiplier with valid/ready.
// Optional accumulator enabled by defining MULT_ACC_EN.
module booth_wallace_mult_pipe #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               in_signed,
`ifdef MULT_ACC_EN
    input  logic               acc_clr,
    input  logic               acc_en,
`endif
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_p
);

    localparam int PW = 2 * WIDTH;
    localparam int RW = WIDTH + 3;
    localparam int ND = WIDTH / 2 + 1;
    localparam int NV = ND + 2;

    function automatic int calc_levels(input int n);
        int c;
        int l;
        c = n;
        l = 0;
        while (c > 2) begin
            c = 2 * (c / 3) + c % 3;
            l++;
        end
        return l;
    endfunction

    // Undoes the +2^(RW-1) bias introduced by inverting each row's sign bit.
    function automatic logic [PW-1:0] calc_k();
        logic [PW-1:0] k;
        k = '0;
        for (int i = 0; i < ND; i++) begin
            k = k - (PW'(1) << (RW - 1 + 2 * i));
        end
        return k;
    endfunction

    localparam int          LEVELS = calc_levels(NV);
    localparam logic [PW-1:0] K_CORR = calc_k();

    logic          w_advance;
    logic [RW-1:0] w_a_x;
    logic [WIDTH+2:0] w_b_x;
    logic [RW-1:0] w_row [ND];
    logic [PW-1:0] w_negv;
    logic [PW-1:0] w_sum;
    logic [PW-1:0] w_carry;
    logic [PW-1:0] w_res;

    logic          r_v1, r_v2, r_v3;
    logic [RW-1:0] r_pp [ND];
    logic [PW-1:0] r_negv;
    logic [PW-1:0] r_sum;
    logic [PW-1:0] r_carry;
    logic [PW-1:0] r_p;

    assign w_advance = ~r_v3 | out_ready;
    assign in_ready  = w_advance;
    assign out_valid = r_v3;
    assign out_p     = r_p;

    always_comb begin : ppgen
        logic [2:0]    b3;
        logic          neg;
        logic          one;
        logic          two;
        logic [RW-1:0] mag;
        logic [RW-1:0] row;
        w_a_x  = in_signed ? {{3{in_a[WIDTH-1]}}, in_a} : {3'b000, in_a};
        w_b_x  = {(in_signed ? {2{in_b[WIDTH-1]}} : 2'b00), in_b, 1'b0};
        w_negv = '0;
        for (int i = 0; i < ND; i++) begin
            b3  = w_b_x[2*i +: 3];
            neg = b3[2] & ~(b3[1] & b3[0]);
            one = b3[1] ^ b3[0];
            two = (b3 == 3'b100) || (b3 == 3'b011);
            mag = one ? w_a_x : (two ? {w_a_x[RW-2:0], 1'b0} : '0);
            row = neg ? ~mag : mag;
            w_row[i]      = {~row[RW-1], row[RW-2:0]};
            w_negv[2*i]   = neg;
        end
    end

    always_comb begin : reduce
        logic [PW-1:0] v [NV];
        logic [PW-1:0] n [NV];
        for (int k = 0; k < NV; k++) begin
            v[k] = '0;
            n[k] = '0;
        end
        for (int i = 0; i < ND; i++) begin
            v[i] = PW'(r_pp[i]) << (2 * i);
        end
        v[ND]     = r_negv;
        v[ND + 1] = K_CORR;
        // Fixed-shape carry-save levels: slots past the live count stay zero.
        for (int l = 0; l < LEVELS; l++) begin
            for (int k = 0; k < NV; k++) begin
                n[k] = '0;
            end
            for (int g = 0; g < NV / 3; g++) begin
                n[2*g]     = v[3*g] ^ v[3*g+1] ^ v[3*g+2];
                n[2*g + 1] = ((v[3*g] & v[3*g+1]) | (v[3*g] & v[3*g+2]) |
                              (v[3*g+1] & v[3*g+2])) << 1;
            end
            for (int r = 0; r < NV % 3; r++) begin
                n[2*(NV/3) + r] = v[3*(NV/3) + r];
            end
            for (int k = 0; k < NV; k++) begin
                v[k] = n[k];
            end
        end
        w_sum   = v[0];
        w_carry = v[1];
    end

`ifdef MULT_ACC_EN
    logic          r_acc_en1, r_acc_en2, r_acc_clr1, r_acc_clr2;
    logic [PW-1:0] r_acc;
    logic [PW-1:0] w_base;

    assign w_base = r_acc_clr2 ? '0 : r_acc;
    assign w_res  = r_acc_en2 ? (w_base + r_sum + r_carry) : (r_sum + r_carry);

    // The accumulator advances when a result enters S3; results are never dropped after that.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc_en1  <= 1'b0;
            r_acc_en2  <= 1'b0;
            r_acc_clr1 <= 1'b0;
            r_acc_clr2 <= 1'b0;
            r_acc      <= '0;
        end else if (w_advance) begin
            r_acc_en1  <= acc_en;
            r_acc_clr1 <= acc_clr;
            r_acc_en2  <= r_acc_en1;
            r_acc_clr2 <= r_acc_clr1;
            if (r_v2 && r_acc_en2) begin
                r_acc <= w_res;
            end else if (r_v2 && r_acc_clr2) begin
                r_acc <= '0;
            end
        end
    end
`else
    assign w_res = r_sum + r_carry;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_v1    <= 1'b0;
            r_v2    <= 1'b0;
            r_v3    <= 1'b0;
            r_negv  <= '0;
            r_sum   <= '0;
            r_carry <= '0;
            r_p     <= '0;
            for (int i = 0; i < ND; i++) begin
                r_pp[i] <= '0;
            end
        end else if (w_advance) begin
            r_v1    <= in_valid;
            r_v2    <= r_v1;
            r_v3    <= r_v2;
            r_negv  <= w_negv;
            r_sum   <= w_sum;
            r_carry <= w_carry;
            r_p     <= w_res;
            for (int i = 0; i < ND; i++) begin
                r_pp[i] <= w_row[i];
            end
        end
    end

endmodule

// File: tb/tb_booth_wallace_mult_pipe.sv
// tb/tb_booth_wallace_mult_pipe.sv - randomized scoreboard bench for booth_wallace_mult_pipe.
module tb_booth_wallace_mult_pipe;

    localparam int W = 16;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           in_valid = 1'b0;
    logic           in_signed = 1'b0;
    logic           out_ready = 1'b0;
    logic [W-1:0]   in_a = '0;
    logic [W-1:0]   in_b = '0;
    logic           in_ready;
    logic           out_valid;
    logic [2*W-1:0] out_p;

    int             n_tests = 0;
    int             n_fail = 0;
    int             step_no = 0;
    int             n_in = 0;
    int             n_out = 0;
    bit             chk_lat = 1'b0;
    bit             last_acc = 1'b0;
    bit             prev_hold = 1'b0;
    logic [2*W-1:0] prev_p = '0;
    logic [2*W-1:0] exp_q[$];
    int             acc_q[$];

    booth_wallace_mult_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_signed (in_signed),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_p     (out_p)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [2*W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                             input logic s);
        longint x;
        longint y;
        x = s ? longint'($signed(a)) : longint'({48'd0, a});
        y = s ? longint'($signed(b)) : longint'({48'd0, b});
        return (2*W)'(x * y);
    endfunction

    // One cycle: drive at negedge, then predict what the next rising edge transfers.
    task automatic step(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic s, input logic ordy, input logic [2*W-1:0] exp);
        int lat;
        @(negedge clk);
        step_no++;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        in_signed = s;
        out_ready = ordy;
        #1;
        check("in_ready", in_ready, !out_valid || out_ready);
        if (prev_hold) begin
            check("hold_valid", out_valid, 1'b1);
            check("hold_p", out_p, prev_p);
        end
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("spurious_out", 1'b1, 1'b0);
            end else begin
                check("product", out_p, exp_q.pop_front());
                lat = step_no - acc_q.pop_front();
                if (chk_lat) check("latency", lat, 3);
            end
            n_out++;
        end
        last_acc = in_valid && in_ready;
        if (last_acc) begin
            exp_q.push_back(exp);
            acc_q.push_back(step_no);
            n_in++;
        end
        prev_hold = out_valid && !out_ready;
        prev_p    = out_p;
    endtask

    task automatic drain(input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) begin
            step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        end
        check("drained", exp_q.size(), 0);
        check("in_eq_out", n_out, n_in);
    endtask

    logic [W-1:0]   d_a [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'hFFFF};
    logic [W-1:0]   d_b [4] = '{16'h7FFF, 16'h8000, 16'hFFFF, 16'h0002};
    logic           d_s [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [2*W-1:0] d_p [4] = '{32'h3FFF0001, 32'h40000000, 32'hFFFE0001, 32'hFFFFFFFE};

    initial begin
        logic [W-1:0] ra [8];
        logic [W-1:0] rb [8];
        logic         rs [8];
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         s;
        int           idx;
        int           c;

        repeat (2) @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_out_p", out_p, '0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1'b1);

        chk_lat = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b1, d_a[i], d_b[i], d_s[i], 1'b1, d_p[i]);
            drain(8);
        end

        chk_lat = 1'b0;
        for (int i = 0; i < 8; i++) begin
            ra[i] = W'($urandom);
            rb[i] = W'($urandom);
            rs[i] = 1'($urandom);
        end
        idx = 0;
        c   = 0;
        while (idx < 8 && c < 40) begin
            step(1'b1, ra[idx], rb[idx], rs[idx], !(c >= 4 && c <= 6),
                 model(ra[idx], rb[idx], rs[idx]));
            if (last_acc) idx++;
            c++;
        end
        check("stream_issued", idx, 8);
        drain(12);

        for (int i = 0; i < 300; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            s = 1'($urandom);
            step($urandom_range(0, 3) != 0, a, b, s, $urandom_range(0, 9) < 7, model(a, b, s));
        end
        drain(20);

        chk_lat = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a = W'($urandom);
            b = W'($urandom);
            step(1'b1, a, b, 1'b1, 1'b1, model(a, b, 1'b1));
        end
        @(negedge clk);
        rst      = 1'b1;
        in_valid = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        exp_q.delete();
        acc_q.delete();
        n_in      = 0;
        n_out     = 0;
        prev_hold = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        step(1'b1, a, b, 1'b0, 1'b1, model(a, b, 1'b0));
        drain(8);
        repeat (4) step(1'b0, '0, '0, 1'b0, 1'b1, '0);
        check("post_rst_count", n_out, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
